// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared types and constants for the register-file writeback controller.
// State encoding, register count and address width live here.
package regfile_wb_ctrl_pkg;
  localparam int REG_COUNT = 32;
  localparam int ADDR_W    = 5;
  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(REG_COUNT - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;
endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Writeback bus: two requesters (ALU, load), clear control and the
// register-file write port.
interface regfile_wb_ctrl_if #(parameter int N = 32);
  import regfile_wb_ctrl_pkg::*;

  logic              a_valid_i;
  logic [ADDR_W-1:0] a_addr_i;
  logic [N-1:0]      a_data_i;
  logic              a_ready_o;
  logic              b_valid_i;
  logic [ADDR_W-1:0] b_addr_i;
  logic [N-1:0]      b_data_i;
  logic              b_ready_o;
  logic              clear_i;
  logic              Reg_Write_o;
  logic [ADDR_W-1:0] Write_Register_o;
  logic [N-1:0]      Write_Data_o;
  logic              busy_o;
  logic              done_o;

  modport master (
    output a_valid_i, a_addr_i, a_data_i, b_valid_i, b_addr_i, b_data_i, clear_i,
    input  a_ready_o, b_ready_o, Reg_Write_o, Write_Register_o, Write_Data_o, busy_o, done_o
  );

  modport slave (
    input  a_valid_i, a_addr_i, a_data_i, b_valid_i, b_addr_i, b_data_i, clear_i,
    output a_ready_o, b_ready_o, Reg_Write_o, Write_Register_o, Write_Data_o, busy_o, done_o
  );
endinterface

// File: rtl/regfile_rr_arb2.sv
// Two-way round-robin arbiter; the pointer only moves on a granted tie,
// so lone requests never disturb fairness between the two.
module regfile_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       upd_en,
  input  logic [1:0] valid,
  output logic [1:0] ready
);
  logic ptr_b;  // set: next tie goes to requester 1 (B)

  always_ff @(posedge clk) begin
    if (reset)                 ptr_b <= 1'b0;
    else if (upd_en && &valid) ptr_b <= ~ptr_b;
  end

  always_comb begin
    ready = '0;
    if (en) begin
      if (&valid) ready = ptr_b ? 2'b10 : 2'b01;
      else        ready = valid;
    end
  end
endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback controller: arbitrates ALU/load writebacks onto the register
// file write port and runs a zero-fill sweep of registers 1..31 on request.
module regfile_wb_ctrl
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int N = 32
) (
  input logic              clk,
  input logic              reset,
  regfile_wb_ctrl_if.slave bus
);
  state_e            state, state_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx;
  logic              wr_q, wr_nx;
  logic [ADDR_W-1:0] waddr_q, waddr_nx;
  logic [N-1:0]      wdata_q, wdata_nx;
  logic              done_q, done_nx;
  logic              arb_en;
  logic [1:0]        ready;

  // A pending clear outranks both requesters in the cycle it is seen.
  assign arb_en = ~reset & (state == IDLE) & ~bus.clear_i;

  regfile_rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .en     (arb_en),
    .upd_en (arb_en),
    .valid  ({bus.b_valid_i, bus.a_valid_i}),
    .ready  (ready)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      wr_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      wr_q    <= wr_nx;
      waddr_q <= waddr_nx;
      wdata_q <= wdata_nx;
      done_q  <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    wr_nx    = 1'b0;
    waddr_nx = waddr_q;
    wdata_nx = wdata_q;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.clear_i) begin
          state_nx = CLEAR;
          cnt_nx   = ADDR_W'(1);
          wr_nx    = 1'b1;
          waddr_nx = ADDR_W'(1);
          wdata_nx = '0;
        end else if (ready[0]) begin
          wr_nx    = |bus.a_addr_i;  // x0 is hardwired; drop the write strobe
          waddr_nx = bus.a_addr_i;
          wdata_nx = bus.a_data_i;
        end else if (ready[1]) begin
          wr_nx    = |bus.b_addr_i;
          waddr_nx = bus.b_addr_i;
          wdata_nx = bus.b_data_i;
        end
      end
      CLEAR: begin
        // cnt tracks the register currently on the write port
        if (cnt == LAST_REG) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end else begin
          cnt_nx   = cnt + 1'b1;
          wr_nx    = 1'b1;
          waddr_nx = cnt_nx;
          wdata_nx = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.a_ready_o        = ready[0];
  assign bus.b_ready_o        = ready[1];
  assign bus.Reg_Write_o      = wr_q;
  assign bus.Write_Register_o = waddr_q;
  assign bus.Write_Data_o     = wdata_q;
  assign bus.busy_o           = (state == CLEAR);
  assign bus.done_o           = done_q;
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: directed scenarios plus random traffic,
// checked every cycle against a cycle-level behavioural model.
module tb_regfile_wb_ctrl;
  localparam int N = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_wb_ctrl_if #(.N(N)) bus();
  regfile_wb_ctrl #(.N(N)) dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;

  // model: cpos = register being zero-filled this cycle (0 = not clearing)
  int         cpos;
  bit         tie_a;
  logic       e_wr, e_done;
  logic [4:0] e_addr;
  logic [N-1:0] e_data;
  logic       g_a, g_b;
  logic       pre_done;
  int         busy_cnt, done_cnt;
  logic [4:0] wq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check grants before the edge, registered outputs after it.
  task automatic cyc();
    #2;
    g_a = 1'b0;
    g_b = 1'b0;
    pre_done = bus.done_o;
    if (!reset && cpos == 0 && !bus.clear_i) begin
      if (bus.a_valid_i && bus.b_valid_i) begin
        g_a   = tie_a;
        g_b   = !tie_a;
        tie_a = !tie_a;
      end else begin
        g_a = bus.a_valid_i;
        g_b = bus.b_valid_i;
      end
    end
    chk("a_ready", 32'(bus.a_ready_o), 32'(g_a));
    chk("b_ready", 32'(bus.b_ready_o), 32'(g_b));
    @(posedge clk);
    #1;
    if (reset) begin
      cpos = 0; tie_a = 1'b1;
      e_wr = 1'b0; e_addr = '0; e_data = '0; e_done = 1'b0;
    end else begin
      e_done = (cpos == 31);
      if (cpos == 31) begin
        cpos = 0; e_wr = 1'b0;
      end else if (cpos != 0) begin
        cpos++; e_wr = 1'b1; e_addr = 5'(cpos); e_data = '0;
      end else if (bus.clear_i) begin
        cpos = 1; e_wr = 1'b1; e_addr = 5'd1; e_data = '0;
      end else if (g_a) begin
        e_wr = (bus.a_addr_i != 0); e_addr = bus.a_addr_i; e_data = bus.a_data_i;
      end else if (g_b) begin
        e_wr = (bus.b_addr_i != 0); e_addr = bus.b_addr_i; e_data = bus.b_data_i;
      end else begin
        e_wr = 1'b0;
      end
    end
    chk("reg_write", 32'(bus.Reg_Write_o), 32'(e_wr));
    chk("write_reg", 32'(bus.Write_Register_o), 32'(e_addr));
    chk("write_data", bus.Write_Data_o, e_data);
    chk("busy", 32'(bus.busy_o), 32'(cpos != 0));
    chk("done", 32'(bus.done_o), 32'(e_done));
    if (bus.busy_o) busy_cnt++;
    if (bus.done_o) done_cnt++;
    if (bus.Reg_Write_o) wq.push_back(bus.Write_Register_o);
  endtask

  // Random requesters: a granted or idle requester may issue anew, a loser holds.
  task automatic gen();
    if (g_a || !bus.a_valid_i) begin
      bus.a_valid_i = ($urandom_range(0, 2) != 0);
      bus.a_addr_i  = 5'($urandom_range(0, 31));
      bus.a_data_i  = $urandom;
    end
    if (g_b || !bus.b_valid_i) begin
      bus.b_valid_i = ($urandom_range(0, 2) != 0);
      bus.b_addr_i  = 5'($urandom_range(0, 31));
      bus.b_data_i  = $urandom;
    end
    bus.clear_i = ($urandom_range(0, 39) == 0);
  endtask

  string gseq;
  int    zeros, cycles;
  logic  ord_ok;

  initial begin
    cpos = 0; tie_a = 1'b1; busy_cnt = 0; done_cnt = 0;
    e_wr = 1'b0; e_addr = '0; e_data = '0; e_done = 1'b0;
    g_a = 1'b0; g_b = 1'b0;
    // requests held high through reset must not be granted
    reset = 1'b1;
    bus.a_valid_i = 1'b1; bus.a_addr_i = 5'd3; bus.a_data_i = 32'h33;
    bus.b_valid_i = 1'b1; bus.b_addr_i = 5'd4; bus.b_data_i = 32'h44;
    bus.clear_i = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    bus.a_valid_i = 1'b0; bus.b_valid_i = 1'b0;

    // A only
    bus.a_valid_i = 1'b1; bus.a_addr_i = 5'd5; bus.a_data_i = 32'hDEADBEEF;
    cyc();
    chk("a_only_wr", 32'(bus.Reg_Write_o), 32'd1);
    chk("a_only_addr", 32'(bus.Write_Register_o), 32'd5);
    chk("a_only_data", bus.Write_Data_o, 32'hDEADBEEF);
    bus.a_valid_i = 1'b0;
    cyc();

    // tie: grants alternate starting with A; losers keep their payload
    bus.a_valid_i = 1'b1; bus.a_addr_i = 5'd1; bus.a_data_i = 32'h11;
    bus.b_valid_i = 1'b1; bus.b_addr_i = 5'd2; bus.b_data_i = 32'h22;
    gseq = "";
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (g_a) begin
        gseq = {gseq, "A"};
        bus.a_addr_i = 5'(10 + i); bus.a_data_i = 32'(32'hA0 + i);
      end else if (g_b) begin
        gseq = {gseq, "B"};
        bus.b_addr_i = 5'(20 + i); bus.b_data_i = 32'(32'hB0 + i);
      end
    end
    total++;
    assert (gseq == "ABAB") else begin
      bad++;
      $error("FAIL tie_order observed=%s expected=ABAB", gseq);
    end
    bus.a_valid_i = 1'b0; bus.b_valid_i = 1'b0;
    cyc();

    // x0 write from B
    bus.b_valid_i = 1'b1; bus.b_addr_i = 5'd0; bus.b_data_i = 32'h1234;
    cyc();
    chk("x0_b_grant", 32'(g_b), 32'd1);
    chk("x0_no_wr", 32'(bus.Reg_Write_o), 32'd0);
    bus.b_valid_i = 1'b0;
    cyc();

    // random traffic, with occasional clears (some landing mid-clear)
    for (int i = 0; i < 400; i++) begin
      gen();
      cyc();
    end
    bus.a_valid_i = 1'b0; bus.b_valid_i = 1'b0; bus.clear_i = 1'b0;
    for (int i = 0; i < 34; i++) cyc();

    // clear with A waiting: A granted in the done cycle
    busy_cnt = 0; done_cnt = 0; wq.delete();
    bus.a_valid_i = 1'b1; bus.a_addr_i = 5'd7; bus.a_data_i = 32'h77;
    bus.clear_i = 1'b1;
    zeros = 0; cycles = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      bus.clear_i = (i == 5);  // a stray clear mid-sweep is ignored
      cycles++;
      if (g_a) break;
      zeros++;
    end
    bus.clear_i = 1'b0;
    bus.a_valid_i = 1'b0;
    chk("clr_a_wait", 32'(zeros), 32'd32);
    chk("clr_grant_in_done", 32'(pre_done), 32'd1);
    chk("clr_busy_cycles", 32'(busy_cnt), 32'd31);
    chk("clr_done_pulses", 32'(done_cnt), 32'd1);
    ord_ok = (wq.size() == 32);
    for (int i = 0; i < 31 && ord_ok; i++) if (wq[i] != 5'(i + 1)) ord_ok = 1'b0;
    chk("clr_write_order", 32'(ord_ok), 32'd1);
    chk("clr_then_a_addr", 32'(bus.Write_Register_o), 32'd7);
    cyc();

    // reset aborts a sweep in its 10th cycle
    done_cnt = 0;
    bus.clear_i = 1'b1;
    cyc();
    bus.clear_i = 1'b0;
    for (int i = 0; i < 9; i++) cyc();
    chk("abort_pos", 32'(bus.Write_Register_o), 32'd10);
    reset = 1'b1;
    cyc();
    chk("abort_wr", 32'(bus.Reg_Write_o), 32'd0);
    chk("abort_addr", 32'(bus.Write_Register_o), 32'd0);
    chk("abort_busy", 32'(bus.busy_o), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) cyc();
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    bus.a_valid_i = 1'b1; bus.a_addr_i = 5'd9; bus.a_data_i = 32'hCAFE;
    cyc();
    chk("abort_a_grant", 32'(g_a), 32'd1);
    chk("abort_a_data", bus.Write_Data_o, 32'hCAFE);
    bus.a_valid_i = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_wb_ctrl.md
REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

Interface
REQ-001 SHALL have parameter N, default 32, meaning data width of the register file write port.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-004 SHALL have ports a_valid_i (input, 1), a_addr_i (input, 5), a_data_i (input, N), a_ready_o (output, 1); requester A is ALU writeback.
REQ-005 SHALL have ports b_valid_i (input, 1), b_addr_i (input, 5), b_data_i (input, N), b_ready_o (output, 1); requester B is load writeback.
REQ-006 SHALL have port clear_i, input, 1, a one-cycle pulse requesting zero-fill of registers 1..31.
REQ-007 SHALL have ports Reg_Write_o (output, 1), Write_Register_o (output, 5) and Write_Data_o (output, N), driving the register file write port.
REQ-008 SHALL have port busy_o, output, 1, high while the clear sequence runs.
REQ-009 SHALL have port done_o, output, 1, a one-cycle pulse when the clear sequence finishes.

Function
REQ-010 SHALL use states IDLE and CLEAR.
REQ-011 In IDLE, a handshake on a requester SHALL occur in the cycle where its valid_i and ready_o are both high.
REQ-012 Write outputs SHALL be registered: a handshake in cycle t SHALL drive Reg_Write_o, Write_Register_o and Write_Data_o in cycle t+1 with the granted addr/data.
REQ-013 With only one requester valid in IDLE, that requester SHALL get ready_o=1.
REQ-014 With both requesters valid, the block SHALL grant round-robin: the requester not granted at the last tie wins; the first tie after reset goes to A.
REQ-015 A single-requester grant SHALL NOT update the round-robin pointer.
REQ-016 ready_o SHALL be asserted only for the winner; the loser SHALL hold its valid, addr and data until granted.
REQ-017 A handshake with addr 0 SHALL complete normally, but Reg_Write_o SHALL stay 0 in cycle t+1.
REQ-018 With no handshake and not in CLEAR, Reg_Write_o SHALL be 0 in the next cycle; Write_Register_o and Write_Data_o SHALL hold their previous values.
REQ-019 clear_i high in IDLE SHALL enter CLEAR next cycle, take priority over requests, and force both ready_o to 0 in that cycle.
REQ-020 In CLEAR, a 5-bit counter starting at 1 SHALL drive Reg_Write_o=1, Write_Register_o=counter and Write_Data_o=0, incrementing each cycle through 31.
REQ-021 The clear sequence SHALL take exactly 31 write cycles.
REQ-022 busy_o SHALL be high for exactly the 31 CLEAR cycles.
REQ-023 Both ready_o SHALL be 0 throughout CLEAR.
REQ-024 clear_i asserted during CLEAR SHALL be ignored.
REQ-025 In the cycle after the write to register 31, the block SHALL pulse done_o for one cycle, return to IDLE and accept requests in that same cycle.
REQ-026 The counter SHALL NOT wrap: after reaching 31 it SHALL exit CLEAR.

Reset
REQ-027 While reset is high, the state SHALL be IDLE and the round-robin pointer SHALL favour A.
REQ-028 While reset is high, Reg_Write_o, Write_Register_o, Write_Data_o, busy_o and done_o SHALL be 0.
REQ-029 While reset is high, a_ready_o and b_ready_o SHALL be 0.
REQ-030 Reset asserted mid-CLEAR SHALL abort the sequence without a done_o pulse; the remaining registers stay unwritten.

Structure
REQ-031 A shared package SHALL hold the state enum, REG_COUNT=32 and ADDR_W=5.
REQ-032 The 2-way round-robin arbiter SHALL be a sub-module named regfile_rr_arb2, with valid inputs, ready outputs and a pointer-update enable.
REQ-033 The top level SHALL contain the FSM, the clear counter and the output registers.
REQ-034 The block SHALL instantiate no register-file storage.

Verification
REQ-035 A only: A writes addr 5, data 0xDEADBEEF -> a_ready_o=1 same cycle; next cycle Reg_Write_o=1, Write_Register_o=5, Write_Data_o=0xDEADBEEF.
REQ-036 Tie: A and B valid for 4 cycles after reset -> grants A, B, A, B; each loser holds until granted.
REQ-037 x0 write: B writes addr 0, data 0x1234 -> b_ready_o=1; next cycle Reg_Write_o=0.
REQ-038 Clear: clear_i pulse with A valid -> a_ready_o=0 for 32 cycles; writes of 0 to registers 1..31 in order; busy_o high 31 cycles; done_o pulses once; A granted in the done cycle.
REQ-039 Reset abort: reset asserted at the 10th CLEAR cycle -> next cycle all outputs are 0, state is IDLE, no done_o; a subsequent A request is granted normally.
